// File: rtl/button_event.sv
// button_event: turns a debounced button level into discrete events.
//   press / release_strobe : one-cycle strobes on the press and release edges
//   long_press             : one-cycle strobe once the hold reaches LONG_CYCLES
//   repeat_strobe          : auto-repeat strobe every REPEAT_CYCLES while long-pressed
//   held                   : registered pressed level
//   press_count            : wrapping count of presses
// The release and repeat strobes carry a _strobe suffix because "release" and
// "repeat" are reserved words in SystemVerilog.
// Optional feature macro: BUTTON_EVENT_REPEAT_EN (auto-repeat). When it is not
// defined, repeat_strobe stays 0 and the hold counter is frozen in LONG.
module button_event #(
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 4,
    parameter int CNT_W         = 8,
    parameter int PRESS_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               signal,
    output logic               press,
    output logic               release_strobe,
    output logic               long_press,
    output logic               repeat_strobe,
    output logic               held,
    output logic [PRESS_W-1:0] press_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    // Counter value at which the hold turns into a long press.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
    // Counter value at which a repeat strobe fires in LONG.
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PRESS_W-1:0] PRESS_ZERO = {PRESS_W{1'b0}};
    localparam logic [PRESS_W-1:0] PRESS_ONE  = {{(PRESS_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   hold_cnt_r;
    logic [CNT_W-1:0]   hold_cnt_s;
    logic               sig_q;
    logic               press_s;
    logic               release_s;
    logic               long_s;
    logic               repeat_s;
    logic               held_s;
    logic [PRESS_W-1:0] press_count_s;

    // Next-state, hold counter and strobe decode; every strobe defaults low so
    // none can last more than one cycle, and a release always wins a collision.
    always_comb begin
        state_s       = state_r;
        hold_cnt_s    = hold_cnt_r;
        press_s       = 1'b0;
        release_s     = 1'b0;
        long_s        = 1'b0;
        repeat_s      = 1'b0;
        press_count_s = press_count;
        case (state_r)
            IDLE: begin
                // sig_q is 0 after reset, so a level held through reset
                // still produces a press at the first edge that sees it.
                if (signal && !sig_q) begin
                    state_s       = PRESSED;
                    hold_cnt_s    = CNT_ZERO;
                    press_s       = 1'b1;
                    press_count_s = press_count + PRESS_ONE;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESSED: begin
                if (!signal) begin
                    state_s   = IDLE;
                    release_s = 1'b1;
                end else if (hold_cnt_r == LONG_LAST) begin
                    state_s    = LONG;
                    hold_cnt_s = CNT_ZERO;
                    long_s     = 1'b1;
                end else begin
                    hold_cnt_s = hold_cnt_r + CNT_ONE;
                end
            end
            LONG: begin
                if (!signal) begin
                    state_s   = IDLE;
                    release_s = 1'b1;
                end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (hold_cnt_r == REP_LAST) begin
                        hold_cnt_s = CNT_ZERO;
                        repeat_s   = 1'b1;
                    end else begin
                        hold_cnt_s = hold_cnt_r + CNT_ONE;
                    end
`else
                    hold_cnt_s = hold_cnt_r;
`endif
                end
            end
            default: begin
                state_s    = IDLE;
                hold_cnt_s = CNT_ZERO;
            end
        endcase
        held_s = (state_s != IDLE);
    end

    // State, counters and all outputs are registered; reset aborts any hold
    // without emitting a release.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            hold_cnt_r     <= CNT_ZERO;
            sig_q          <= 1'b0;
            press          <= 1'b0;
            release_strobe <= 1'b0;
            long_press     <= 1'b0;
            repeat_strobe  <= 1'b0;
            held           <= 1'b0;
            press_count    <= PRESS_ZERO;
        end else begin
            state_r        <= state_s;
            hold_cnt_r     <= hold_cnt_s;
            sig_q          <= signal;
            press          <= press_s;
            release_strobe <= release_s;
            long_press     <= long_s;
            repeat_strobe  <= repeat_s;
            held           <= held_s;
            press_count    <= press_count_s;
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Directed self-checking bench for button_event with default parameters.
// Output vector order: {press, release_strobe, long_press, repeat_strobe, held}.
module tb_button_event;

    logic       clock;
    logic       reset;
    logic       signal;
    logic       press;
    logic       release_strobe;
    logic       long_press;
    logic       repeat_strobe;
    logic       held;
    logic [7:0] press_count;

    int checks;
    int failures;
    logic [7:0] exp_cnt;

    button_event dut (
        .clock          (clock),
        .reset          (reset),
        .signal         (signal),
        .press          (press),
        .release_strobe (release_strobe),
        .long_press     (long_press),
        .repeat_strobe  (repeat_strobe),
        .held           (held),
        .press_count    (press_count)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one level, clock one edge, sample #1 after it.
    task automatic cycle(input logic s);
        signal = s;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] e, input logic [7:0] cnt);
        check_val({tag, ".ev"}, {27'd0, press, release_strobe, long_press, repeat_strobe, held}, {27'd0, e});
        check_val({tag, ".cnt"}, {24'd0, press_count}, {24'd0, cnt});
    endtask

    initial begin
        logic [4:0] e;
        checks   = 0;
        failures = 0;
        exp_cnt  = 8'd0;
        reset    = 1'b1;
        signal   = 1'b1;

        // 1. Reset with button held, then press at first post-reset edge.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1);
            expect_out($sformatf("rst[%0d]", i), 5'b00000, 8'd0);
        end
        reset = 1'b0;
        cycle(1'b1);
        exp_cnt = 8'd1;
        expect_out("rst_press", 5'b10001, 8'd1);
        cycle(1'b1);
        expect_out("rst_hold", 5'b00001, exp_cnt);
        cycle(1'b0);
        expect_out("rst_rel", 5'b01000, exp_cnt);
        cycle(1'b0);
        expect_out("rst_idle", 5'b00000, exp_cnt);

        // 2. Short tap of 5 edges.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1);
            if (i == 0) exp_cnt = exp_cnt + 8'd1;
            expect_out($sformatf("tap[%0d]", i), (i == 0) ? 5'b10001 : 5'b00001, exp_cnt);
        end
        cycle(1'b0);
        expect_out("tap_rel", 5'b01000, exp_cnt);
        cycle(1'b0);
        expect_out("tap_idle", 5'b00000, exp_cnt);

        // 3. Long hold of 30 edges.
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1);
            e = 5'b00001;
            if (i == 0) begin
                e = e | 5'b10000;
                exp_cnt = exp_cnt + 8'd1;
            end
            if (i == 16) e = e | 5'b00100;
`ifdef BUTTON_EVENT_REPEAT_EN
            if (i == 20 || i == 24 || i == 28) e = e | 5'b00010;
`endif
            expect_out($sformatf("long[%0d]", i), e, exp_cnt);
        end
        cycle(1'b0);
        expect_out("long_rel", 5'b01000, exp_cnt);
        cycle(1'b0);
        expect_out("long_idle", 5'b00000, exp_cnt);

        // 4. Release colliding with the long-press edge and a repeat edge.
        for (int d = 16; d <= 20; d += 4) begin
            for (int i = 0; i < d; i++) begin
                cycle(1'b1);
                e = 5'b00001;
                if (i == 0) begin
                    e = e | 5'b10000;
                    exp_cnt = exp_cnt + 8'd1;
                end
                if (i == 16) e = e | 5'b00100;
                expect_out($sformatf("col%0d[%0d]", d, i), e, exp_cnt);
            end
            cycle(1'b0);
            expect_out($sformatf("col%0d_rel", d), 5'b01000, exp_cnt);
            cycle(1'b0);
            expect_out($sformatf("col%0d_idle", d), 5'b00000, exp_cnt);
        end

        // 5. Clear count, then 257 back-to-back one-cycle taps.
        reset = 1'b1;
        cycle(1'b0);
        expect_out("wrap_rst", 5'b00000, 8'd0);
        reset   = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 257; i++) begin
            cycle(1'b1);
            exp_cnt = exp_cnt + 8'd1;
            expect_out($sformatf("wrap_p[%0d]", i), 5'b10001, exp_cnt);
            cycle(1'b0);
            expect_out($sformatf("wrap_r[%0d]", i), 5'b01000, exp_cnt);
        end
        check_val("wrap_final", {24'd0, press_count}, 32'd1);

        // 6. Reset at E0+10 aborts the hold; held level re-presses after reset.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            if (i == 0) exp_cnt = exp_cnt + 8'd1;
            expect_out($sformatf("mid[%0d]", i), (i == 0) ? 5'b10001 : 5'b00001, exp_cnt);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1);
            expect_out($sformatf("mid_rst[%0d]", i), 5'b00000, 8'd0);
        end
        reset = 1'b0;
        cycle(1'b1);
        expect_out("mid_repress", 5'b10001, 8'd1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1);
            expect_out($sformatf("mid_hold[%0d]", i), 5'b00001, 8'd1);
        end
        cycle(1'b0);
        expect_out("mid_rel", 5'b01000, 8'd1);
        cycle(1'b0);
        expect_out("mid_idle", 5'b00000, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
